scratchpad_stream_reader: RTL and testbench

- Avalon-MM read initiator for the 4096 x 32-bit processor scratchpad. It reads the scratchpad through the scratchpad's second slave port.
- On a start command, it reads LENGTH consecutive words from BASE. Addresses wrap modulo 4096.
- Words are emitted in order on an Avalon-ST source with backpressure. Word-level start-of-packet and end-of-packet flags mark the block.
- Fingerprint/compare logic uses it to consume scratchpad contents without stalling the Nios core.

---
 rtl/scratchpad_stream_reader.sv | 157 +++++++++++++++
 tb/tb_scratchpad_stream_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_stream_reader.sv
// scratchpad_stream_reader
// Avalon-MM read initiator that streams a block of consecutive scratchpad words
// out of an Avalon-ST source with backpressure, tagging start/end of packet.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   cmd_start/base/length block command, sampled only while idle
//   busy, done            status: busy from accepted start through done pulse
//   sp_*                  Avalon-MM read master to the scratchpad (1-cycle read latency)
//   st_*                  Avalon-ST source: data/valid/ready plus sop/eop
module scratchpad_stream_reader #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sp_address,
  output logic              sp_chipselect,
  output logic              sp_write,
  output logic [3:0]        sp_byteenable,
  input  logic [DATA_W-1:0] sp_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0]   DepthC  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0]   CntOne  = CntW'(1);
  localparam logic [ADDR_W:0]   LenOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [PtrW-1:0]   PtrOne  = PtrW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;  // reads still to issue
  logic              first_q, first_d;          // next issued read is word 0

  // Tags travelling with the single in-flight read.
  logic              outstanding_q;
  logic              out_sop_q, out_eop_q;

  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic              fifo_sop_q  [FIFO_DEPTH];
  logic              fifo_eop_q  [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;

  logic issue, push, pop, last_issue;

  // Occupancy plus the in-flight read never exceeds the depth, so the FIFO cannot overflow.
  assign issue      = (state_q == StRun) && ((count_q + CntW'(outstanding_q)) < DepthC);
  assign last_issue = issue && (remaining_q == LenOne);
  assign push       = outstanding_q;
  assign pop        = (count_q != '0) && st_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          if (cmd_length != '0) begin
            state_d     = StRun;
            addr_d      = cmd_base;
            remaining_d = cmd_length;
            first_d     = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d      = addr_q + AddrOne;
          remaining_d = remaining_q - LenOne;
          first_d     = 1'b0;
          if (last_issue) state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave as soon as the final word pops so done lands one cycle after it.
        if (!outstanding_q && ((count_q == '0) || ((count_q == CntOne) && pop))) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remaining_q   <= '0;
      first_q       <= 1'b0;
      outstanding_q <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      first_q       <= first_d;
      outstanding_q <= issue;
      out_sop_q     <= first_q;
      out_eop_q     <= last_issue;
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wptr_q] <= sp_readdata;
      fifo_sop_q[wptr_q]  <= out_sop_q;
      fifo_eop_q[wptr_q]  <= out_eop_q;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign sp_address    = addr_q;
  assign sp_chipselect = issue;
  assign sp_write      = 1'b0;
  assign sp_byteenable = 4'hF;

  // Head outputs are gated so they read as zero whenever the FIFO is empty.
  assign st_valid = (count_q != '0);
  assign st_data  = st_valid ? fifo_data_q[rptr_q] : '0;
  assign st_sop   = st_valid & fifo_sop_q[rptr_q];
  assign st_eop   = st_valid & fifo_eop_q[rptr_q];

endmodule

// File: tb/tb_scratchpad_stream_reader.sv
module tb_scratchpad_stream_reader;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_start;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_length;
  logic          busy, done;
  logic [AW-1:0] sp_address;
  logic          sp_chipselect, sp_write;
  logic [3:0]    sp_byteenable;
  logic [DW-1:0] sp_readdata;
  logic [DW-1:0] st_data;
  logic          st_valid, st_ready, st_sop, st_eop;

  scratchpad_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_start    (cmd_start),
    .cmd_base     (cmd_base),
    .cmd_length   (cmd_length),
    .busy         (busy),
    .done         (done),
    .sp_address   (sp_address),
    .sp_chipselect(sp_chipselect),
    .sp_write     (sp_write),
    .sp_byteenable(sp_byteenable),
    .sp_readdata  (sp_readdata),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_sop       (st_sop),
    .st_eop       (st_eop)
  );

  always #5 clk = ~clk;

  // Scratchpad model: address registered on the edge, data valid the next cycle.
  function automatic logic [31:0] exp_word(input int unsigned a);
    if (a >= 32'h100 && a <= 32'h107) return 32'hA0 + (a - 32'h100);
    return 32'h5000_0000 + a;
  endfunction

  logic [DW-1:0] spmem [4096];
  logic [DW-1:0] rd_q;
  initial for (int i = 0; i < 4096; i++) spmem[i] = exp_word(i);
  always @(posedge clk) if (sp_chipselect) rd_q <= spmem[sp_address];
  assign sp_readdata = rd_q;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor, sampled on the falling edge.
  logic [31:0]   rx_data [$];
  bit            rx_sop  [$];
  bit            rx_eop  [$];
  logic [AW-1:0] rx_addr [$];
  int  cs_count, done_count, done_cyc, eop_cyc;
  bit  done_seen, busy_at_done;

  always @(negedge clk) begin
    if (!reset) begin
      if (sp_chipselect) begin
        cs_count = cs_count + 1;
        rx_addr.push_back(sp_address);
      end
      if (st_valid && st_ready) begin
        rx_data.push_back(st_data);
        rx_sop.push_back(st_sop);
        rx_eop.push_back(st_eop);
        if (st_eop) eop_cyc = cyc;
      end
      if (done) begin
        done_count   = done_count + 1;
        done_cyc     = cyc;
        done_seen    = 1'b1;
        busy_at_done = busy;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rx_data.delete(); rx_sop.delete(); rx_eop.delete(); rx_addr.delete();
    cs_count = 0; done_count = 0; done_seen = 1'b0; busy_at_done = 1'b0;
    done_cyc = 0; eop_cyc = 0;
  endtask

  // mode: 0 = ready high, 1 = ready low 20 cycles then high, 2 = random ready
  task automatic run_block(input logic [AW-1:0] base, input logic [AW:0] len, input int mode,
                           input bit poke, input logic [31:0] ef, input logic [31:0] el);
    int start_cyc, bad_data, bad_addr, bad_flag;
    clear_mon();
    @(posedge clk); #1;
    st_ready   = (mode == 0);
    cmd_base   = base;
    cmd_length = len;
    cmd_start  = 1'b1;
    start_cyc  = cyc;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    if (mode == 1) begin
      repeat (20) @(posedge clk);
      #1;
      chk("stall_reads", cs_count, DEPTH);
      chk("stall_no_words", rx_data.size(), 0);
      st_ready = 1'b1;
    end
    for (int c = 0; c < 20000 && !done_seen; c++) begin
      @(posedge clk); #1;
      if (mode == 2) st_ready = 1'($urandom_range(0, 1));
      if (poke && c == 3) begin
        cmd_base = 12'h007; cmd_length = 13'd2; cmd_start = 1'b1;
      end else begin
        cmd_start = 1'b0;
      end
    end
    cmd_start = 1'b0;
    chk("done_seen", done_seen, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_done", busy, 0);
    chk("valid_after_done", st_valid, 0);
    chk("done_count", done_count, 1);
    chk("busy_at_done", busy_at_done, 1);
    chk("word_count", rx_data.size(), len);
    chk("read_count", cs_count, len);
    bad_data = 0; bad_addr = 0; bad_flag = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== exp_word((base + i) % 4096)) bad_data++;
      if (rx_sop[i] !== (i == 0)) bad_flag++;
      if (rx_eop[i] !== (i == int'(len) - 1)) bad_flag++;
    end
    for (int i = 0; i < rx_addr.size(); i++)
      if (rx_addr[i] !== AW'((base + i) % 4096)) bad_addr++;
    chk("data_order", bad_data, 0);
    chk("sop_eop_flags", bad_flag, 0);
    chk("addr_seq", bad_addr, 0);
    if (len != 0) begin
      chk("first_word", rx_data[0], ef);
      chk("last_word", rx_data[rx_data.size()-1], el);
      chk("eop_to_done", done_cyc - eop_cyc, 1);
    end else begin
      chk("len0_done_fast", (done_cyc - start_cyc) <= 2, 1);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;
    bit            poke;
    logic [31:0]   exp_first;
    logic [31:0]   exp_last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{12'h100, 13'd8,    0, 1'b1, 32'h0000_00A0, 32'h0000_00A7};
    vecs[1] = '{12'hFFE, 13'd4,    0, 1'b0, 32'h5000_0FFE, 32'h5000_0001};
    vecs[2] = '{12'h040, 13'd16,   1, 1'b0, 32'h5000_0040, 32'h5000_004F};
    vecs[3] = '{12'h000, 13'd1,    0, 1'b0, 32'h5000_0000, 32'h5000_0000};
    vecs[4] = '{12'h123, 13'd0,    0, 1'b0, 32'h0,         32'h0};
    vecs[5] = '{12'h123, 13'd4096, 2, 1'b0, 32'h5000_0123, 32'h5000_0122};

    clear_mon();
    reset = 1'b1; cmd_start = 1'b0; cmd_base = '0; cmd_length = '0; st_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", sp_chipselect, 0);
    chk("rst_valid", st_valid, 0);
    chk("rst_sop_eop", {st_sop, st_eop}, 0);
    chk("rst_addr", sp_address, 0);
    chk("rst_data", st_data, 0);
    chk("const_write", sp_write, 0);
    chk("const_be", sp_byteenable, 4'hF);
    reset = 1'b0;

    for (int v = 0; v < 6; v++)
      run_block(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].poke,
                vecs[v].exp_first, vecs[v].exp_last);

    // Reset in the middle of a block: everything clears and no done follows.
    clear_mon();
    @(posedge clk); #1;
    st_ready = 1'b1; cmd_base = 12'h200; cmd_length = 13'd10; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    for (int c = 0; c < 100 && rx_data.size() < 5; c++) begin
      @(posedge clk); #1;
    end
    chk("mid_words_before_reset", rx_data.size(), 5);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_outputs",
        {busy, done, sp_chipselect, st_valid, st_sop, st_eop, sp_address, st_data}, 0);
    reset = 1'b0;
    clear_mon();
    repeat (15) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_count, 0);
    chk("mid_rst_no_reads", cs_count, 0);
    chk("mid_rst_no_words", rx_data.size(), 0);
    run_block(12'h010, 13'd3, 0, 1'b0, 32'h5000_0010, 32'h5000_0012);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
